// File: rtl/framebuffer_scanout.sv
// Raster scanout: generates 800x480@60 timing, reads the framebuffer with a
// per-frame horizontal scroll (wrapping at FB_WIDTH) and expands palette indices to RGB.
module framebuffer_scanout #(
  parameter int unsigned COOR_WIDTH   = 12,
  parameter int unsigned FB_WIDTH     = 1280,
  parameter int unsigned FB_HEIGHT    = 300,
  parameter int unsigned H_ACTIVE     = 800,
  parameter int unsigned H_FP         = 40,
  parameter int unsigned H_SYNC       = 128,
  parameter int unsigned H_BP         = 88,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  input  logic [COOR_WIDTH-1:0] scroll_x,
  output logic [COOR_WIDTH-1:0] read_x,
  output logic [COOR_WIDTH-1:0] read_y,
  output logic                  read_en,
  input  logic [2:0]            read_palette,
  output logic [23:0]           rgb,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COOR_WIDTH-1:0] H_LAST   = COOR_WIDTH'(H_TOTAL - 1);
  localparam logic [COOR_WIDTH-1:0] V_LAST   = COOR_WIDTH'(V_TOTAL - 1);
  localparam logic [COOR_WIDTH-1:0] H_ACT_C  = COOR_WIDTH'(H_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] V_ACT_C  = COOR_WIDTH'(V_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] FB_H_C   = COOR_WIDTH'(FB_HEIGHT);
  localparam logic [COOR_WIDTH-1:0] FB_W_C   = COOR_WIDTH'(FB_WIDTH);
  localparam logic [COOR_WIDTH-1:0] HS_START = COOR_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COOR_WIDTH-1:0] HS_END   = COOR_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COOR_WIDTH-1:0] VS_START = COOR_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COOR_WIDTH-1:0] VS_END   = COOR_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COOR_WIDTH:0]   FB_W_X   = (COOR_WIDTH + 1)'(FB_WIDTH);

  logic [COOR_WIDTH-1:0] h;
  logic [COOR_WIDTH-1:0] v;
  logic [COOR_WIDTH-1:0] scroll_l;

  logic                  h_end;
  logic                  v_end;
  logic                  active;
  logic                  in_fb;
  logic                  hs_win;
  logic                  vs_win;
  logic [COOR_WIDTH:0]   sum;
  logic [COOR_WIDTH:0]   wrapped;

  logic [READ_LATENCY-1:0] act_d;
  logic [READ_LATENCY-1:0] fb_d;
  logic [READ_LATENCY-1:0] hs_d;
  logic [READ_LATENCY-1:0] vs_d;

  // Raster counters and the once-per-frame scroll latch
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      h        <= '0;
      v        <= '0;
      scroll_l <= '0;
    end else begin
      if (h_end) begin
        h <= '0;
        if (v_end) v <= '0;
        else       v <= v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (h_end && v_end)
        scroll_l <= (scroll_x >= FB_W_C) ? '0 : scroll_x;
    end
  end

  always_comb begin
    h_end   = (h == H_LAST);
    v_end   = (v == V_LAST);
    active  = (h < H_ACT_C) && (v < V_ACT_C);
    // Counters sit at (0,0) during reset, so the read strobe is held off explicitly
    in_fb   = active && (v < FB_H_C) && !rst;
    hs_win  = (h >= HS_START) && (h < HS_END);
    vs_win  = (v >= VS_START) && (v < VS_END);
    sum     = {1'b0, h} + {1'b0, scroll_l};
    wrapped = (sum >= FB_W_X) ? (sum - FB_W_X) : sum;
  end

  assign read_en     = in_fb;
  assign read_x      = in_fb ? wrapped[COOR_WIDTH-1:0] : '0;
  assign read_y      = in_fb ? v : '0;
  assign frame_start = h_end && v_end;

  // Control bits ride a delay line matching the RAM latency, then one output register
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      act_d <= '0;
      fb_d  <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      act_d[0] <= active;
      fb_d[0]  <= in_fb;
      hs_d[0]  <= hs_win;
      vs_d[0]  <= vs_win;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        act_d[i] <= act_d[i-1];
        fb_d[i]  <= fb_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
      de    <= act_d[READ_LATENCY-1];
      hsync <= ~hs_d[READ_LATENCY-1];
      vsync <= ~vs_d[READ_LATENCY-1];
      rgb   <= fb_d[READ_LATENCY-1] ?
               {{8{read_palette[2]}}, {8{read_palette[1]}}, {8{read_palette[0]}}} : '0;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout on a shrunken raster; a reference raster model feeds
// a scoreboard of expected pixel outputs, and scenario tasks probe specific points.
module tb_framebuffer_scanout;

  localparam int CW    = 12;
  localparam int FBW   = 20;
  localparam int FBH   = 8;
  localparam int HA    = 16;
  localparam int HFP   = 2;
  localparam int HS    = 4;
  localparam int HBP   = 3;
  localparam int VA    = 12;
  localparam int VFP   = 1;
  localparam int VS    = 2;
  localparam int VBP   = 2;
  localparam int LAT   = 2;
  localparam int HT    = HA + HFP + HS + HBP;
  localparam int VT    = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic          clk_33m = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] scroll_x = '0;
  logic [CW-1:0] read_x;
  logic [CW-1:0] read_y;
  logic          read_en;
  logic [2:0]    read_palette;
  logic [23:0]   rgb;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          frame_start;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  framebuffer_scanout #(
    .COOR_WIDTH(CW), .FB_WIDTH(FBW), .FB_HEIGHT(FBH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .READ_LATENCY(LAT)
  ) dut (
    .clk_33m(clk_33m), .rst(rst), .scroll_x(scroll_x),
    .read_x(read_x), .read_y(read_y), .read_en(read_en),
    .read_palette(read_palette), .rgb(rgb), .de(de),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk_33m = ~clk_33m;

  // RAM model: palette index is the low 3 bits of the column; 7 on idle cycles
  logic [2:0] ram_d0 = 3'b0;
  logic [2:0] ram_d1 = 3'b0;
  always @(posedge clk_33m) begin
    ram_d0 <= read_en ? read_x[2:0] : 3'b111;
    ram_d1 <= ram_d0;
  end
  assign read_palette = ram_d1;

  // Reference raster model and scoreboard
  int mh = 0, mv = 0, msc = 0;
  logic [26:0] sbq[$];

  always @(negedge clk_33m) begin
    int x, sum;
    logic act, infb, hsw, vsw, fs;
    logic [2:0] p;
    logic [26:0] expv, gotv;
    if (rst) begin
      mh = 0; mv = 0; msc = 0;
      sbq.delete();
      repeat (LAT + 1) sbq.push_back({1'b0, 1'b1, 1'b1, 24'h0});
    end else begin
      act  = (mh < HA) && (mv < VA);
      infb = act && (mv < FBH);
      hsw  = (mh >= HA + HFP) && (mh < HA + HFP + HS);
      vsw  = (mv >= VA + VFP) && (mv < VA + VFP + VS);
      fs   = (mh == HT - 1) && (mv == VT - 1);
      sum  = mh + msc;
      x    = (sum >= FBW) ? sum - FBW : sum;
      p    = x[2:0];
      n_cmp++;
      if (read_en !== infb || read_x !== (infb ? CW'(x) : '0) ||
          read_y !== (infb ? CW'(mv) : '0) || frame_start !== fs) begin
        n_bad++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL read_port at (%0d,%0d): en=%b x=%0d y=%0d fs=%b, want en=%b x=%0d y=%0d fs=%b",
                   mh, mv, read_en, read_x, read_y, frame_start, infb, infb ? x : 0, infb ? mv : 0, fs);
        end
      end
      expv = {act, ~hsw, ~vsw, infb ? {{8{p[2]}}, {8{p[1]}}, {8{p[0]}}} : 24'h0};
      sbq.push_back(expv);
      gotv = sbq.pop_front();
      n_cmp++;
      if ({de, hsync, vsync, rgb} !== gotv) begin
        n_bad++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL pixel_out: de/hs/vs/rgb=%b%b%b/%h want %b%b%b/%h",
                   de, hsync, vsync, rgb, gotv[26], gotv[25], gotv[24], gotv[23:0]);
        end
      end
      if (fs) msc = (scroll_x >= FBW) ? 0 : int'(scroll_x);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  end

  task automatic drive_scroll(input int val);
    @(posedge clk_33m);
    #1 scroll_x = CW'(val);
  endtask

  // Lands on the negedge of raster position (th,tv) of the next frame
  task automatic goto(input int th, input int tv);
    int guard = 0;
    @(negedge clk_33m);
    while (frame_start !== 1'b1 && guard < 2 * FRAME) begin
      @(negedge clk_33m);
      guard++;
    end
    n_cmp++;
    if (guard >= 2 * FRAME) begin
      n_bad++;
      $display("FAIL goto_timeout: waited %0d cycles, limit %0d", guard, 2 * FRAME);
    end
    repeat (tv * HT + th + 1) @(negedge clk_33m);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk_33m);
    #2;
    n_cmp++;
    if (de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 24'h0 ||
        read_en !== 1'b0 || read_x !== '0 || read_y !== '0 || frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: de=%b hs=%b vs=%b rgb=%h en=%b x=%0d y=%0d fs=%b, want 0 1 1 0 0 0 0 0",
               de, hsync, vsync, rgb, read_en, read_x, read_y, frame_start);
    end
    @(posedge clk_33m);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (read_en !== 1'b1) begin
      n_bad++;
      $display("FAIL first_read_en: got %b want 1", read_en);
    end
  endtask

  // Must start right after reset release: first negedge lies in cycle 0
  task automatic test_timing;
    int de_rise = -1, hs_fall = -1, hs_low = 0, de_cnt = 0;
    logic prev_de = 1'b0, prev_hs = 1'b1, hs_done = 1'b0;
    for (int c = 0; c < 2 * HT; c++) begin
      @(negedge clk_33m);
      if (de && !prev_de && de_rise < 0) de_rise = c;
      if (!hsync && prev_hs && hs_fall < 0) hs_fall = c;
      if (hs_fall >= 0 && !hs_done) begin
        if (!hsync) hs_low++;
        else hs_done = 1'b1;
      end
      if (c >= LAT + 1 && c < LAT + 1 + HT && de) de_cnt++;
      prev_de = de;
      prev_hs = hsync;
    end
    n_cmp++;
    if (de_rise !== LAT + 1) begin
      n_bad++; $display("FAIL de_rise_cycle: got %0d want %0d", de_rise, LAT + 1);
    end
    n_cmp++;
    if (hs_fall !== HA + HFP + LAT + 1) begin
      n_bad++; $display("FAIL hsync_fall_cycle: got %0d want %0d", hs_fall, HA + HFP + LAT + 1);
    end
    n_cmp++;
    if (hs_low !== HS) begin
      n_bad++; $display("FAIL hsync_low_len: got %0d want %0d", hs_low, HS);
    end
    n_cmp++;
    if (de_cnt !== HA) begin
      n_bad++; $display("FAIL de_per_line: got %0d want %0d", de_cnt, HA);
    end
  endtask

  task automatic test_frames;
    int fs[3];
    int k = 0, vlow = 0, vfall = -1, c = 0;
    logic prev_vs = 1'b1;
    while (k < 3 && c < 3 * FRAME + 10) begin
      @(negedge clk_33m);
      if (frame_start) begin fs[k] = c; k++; end
      if (k == 1 && !vsync) begin
        vlow++;
        if (prev_vs && vfall < 0) vfall = c;
      end
      prev_vs = vsync;
      c++;
    end
    n_cmp++;
    if (k < 3) begin
      n_bad++; $display("FAIL frame_start_timeout: saw %0d pulses want 3", k);
    end else begin
      n_cmp++;
      if (fs[1] - fs[0] !== FRAME || fs[2] - fs[1] !== FRAME) begin
        n_bad++;
        $display("FAIL frame_period: got %0d,%0d want %0d", fs[1] - fs[0], fs[2] - fs[1], FRAME);
      end
      n_cmp++;
      if (vlow !== VS * HT) begin
        n_bad++; $display("FAIL vsync_low_len: got %0d want %0d", vlow, VS * HT);
      end
      n_cmp++;
      if (vfall - fs[0] !== LAT + 2 + (VA + VFP) * HT) begin
        n_bad++;
        $display("FAIL vsync_fall_align: got %0d want %0d", vfall - fs[0], LAT + 2 + (VA + VFP) * HT);
      end
    end
  endtask

  task automatic test_wrap;
    drive_scroll(10);
    goto(5, 0);
    n_cmp++;
    if (read_x !== CW'(15)) begin
      n_bad++; $display("FAIL wrap_x15: got %0d want 15", read_x);
    end
    repeat (LAT + 1) @(negedge clk_33m);
    n_cmp++;
    if (rgb !== 24'hFFFFFF || de !== 1'b1) begin
      n_bad++; $display("FAIL wrap_white: rgb=%h de=%b want ffffff 1", rgb, de);
    end
    @(negedge clk_33m);
    n_cmp++;
    if (read_x !== CW'(FBW - 1)) begin
      n_bad++; $display("FAIL wrap_last_col: got %0d want %0d", read_x, FBW - 1);
    end
    @(negedge clk_33m);
    n_cmp++;
    if (read_x !== '0 || read_en !== 1'b1) begin
      n_bad++; $display("FAIL wrap_to_zero: x=%0d en=%b want 0 1", read_x, read_en);
    end
    repeat (LAT + 1) @(negedge clk_33m);
    n_cmp++;
    if (rgb !== 24'h000000 || de !== 1'b1) begin
      n_bad++; $display("FAIL wrap_black: rgb=%h de=%b want 000000 1", rgb, de);
    end
  endtask

  task automatic test_rows;
    goto(0, FBH - 1);
    n_cmp++;
    if (read_en !== 1'b1 || read_y !== CW'(FBH - 1)) begin
      n_bad++; $display("FAIL last_fb_row: en=%b y=%0d want 1 %0d", read_en, read_y, FBH - 1);
    end
    repeat (HT) @(negedge clk_33m);
    n_cmp++;
    if (read_en !== 1'b0 || read_x !== '0 || read_y !== '0) begin
      n_bad++; $display("FAIL beyond_fb_read: en=%b x=%0d y=%0d want 0 0 0", read_en, read_x, read_y);
    end
    repeat (LAT + 1) @(negedge clk_33m);
    n_cmp++;
    if (de !== 1'b1 || rgb !== 24'h0) begin
      n_bad++; $display("FAIL beyond_fb_black: de=%b rgb=%h want 1 000000", de, rgb);
    end
  endtask

  task automatic test_scroll_latch;
    drive_scroll(0);
    goto(0, 0);
    n_cmp++;
    if (read_x !== '0) begin
      n_bad++; $display("FAIL scroll_zero: got %0d want 0", read_x);
    end
    drive_scroll(16);
    repeat (HT) @(negedge clk_33m);
    n_cmp++;
    if (read_x !== '0) begin
      n_bad++; $display("FAIL scroll_midframe: got %0d want 0", read_x);
    end
    goto(0, 0);
    n_cmp++;
    if (read_x !== CW'(16)) begin
      n_bad++; $display("FAIL scroll_next_frame: got %0d want 16", read_x);
    end
    drive_scroll(FBW);
    goto(0, 0);
    n_cmp++;
    if (read_x !== '0) begin
      n_bad++; $display("FAIL scroll_out_of_range: got %0d want 0", read_x);
    end
  endtask

  task automatic test_reset_midline;
    goto(12, 2);
    n_cmp++;
    if (de !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_de: got %b want 1", de);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 24'h0 ||
        read_en !== 1'b0 || read_x !== '0) begin
      n_bad++;
      $display("FAIL async_reset: de=%b hs=%b vs=%b rgb=%h en=%b x=%0d want 0 1 1 0 0 0",
               de, hsync, vsync, rgb, read_en, read_x);
    end
    repeat (3) @(posedge clk_33m);
    #1 rst = 1'b0;
    test_timing();
  endtask

  initial begin
    test_reset();
    test_timing();
    test_frames();
    test_wrap();
    test_rows();
    test_scroll_latch();
    test_reset_midline();
    repeat (4) @(negedge clk_33m);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Reads the painted framebuffer back out of RAM and drives the 800x480@60 display. It generates raster timing, issues one read per active pixel with a horizontal scroll offset and wrap-around, and maps the returned 3-bit palette index to 24-bit RGB. Sync and enable are pipeline-aligned with the pixel data. It sits between the framebuffer RAM read port and the display pins, opposite the painting blocks that write the RAM.

## Interface
Parameters:
- COOR_WIDTH, 12, width of coordinates and counters
- FB_WIDTH, 1280, framebuffer width in pixels
- FB_HEIGHT, 300, framebuffer height in rows
- H_ACTIVE / H_FP / H_SYNC / H_BP, 800 / 40 / 128 / 88, horizontal timing in pixels (H_TOTAL = 1056)
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines (V_TOTAL = 525)
- READ_LATENCY, 2, RAM cycles from address to read_palette valid (≥1)

Ports:
- clk_33m, in, 1, pixel clock; only clock
- rst, in, 1, reset; asynchronous, active-high
- scroll_x, in, COOR_WIDTH, horizontal offset into the framebuffer; sampled once per frame
- read_x, out, COOR_WIDTH, RAM read column
- read_y, out, COOR_WIDTH, RAM read row
- read_en, out, 1, read strobe
- read_palette, in, 3, RAM data; valid READ_LATENCY cycles after the matching read_en
- rgb, out, 24, {R,G,B} pixel, 8 bits per channel
- de, out, 1, display enable
- hsync, out, 1, horizontal sync; active-low
- vsync, out, 1, vertical sync; active-low
- frame_start, out, 1, one-cycle pulse at the start of each frame

## Operation
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1):
  - h increments every cycle.
  - At h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with that same h wrap, v wraps to 0.
- Raster regions:
  - Active: h < H_ACTIVE and v < V_ACTIVE.
  - hsync window: H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync window: V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.
- Scroll latch:
  - scroll_l is loaded from scroll_x in the cycle where h = H_TOTAL-1 and v = V_TOTAL-1. frame_start is asserted in that same cycle.
  - If scroll_x ≥ FB_WIDTH, scroll_l loads 0.
  - Changes to scroll_x mid-frame have no effect until the next frame.
- Read address, combinational from the registered counters:
  - sum = h + scroll_l, computed in COOR_WIDTH+1 bits.
  - read_x = sum ≥ FB_WIDTH ? sum − FB_WIDTH : sum.
  - read_y = v.
- read_en = active and v < FB_HEIGHT.
  - When read_en is low, read_x and read_y are 0.
- Pixel pipeline: active, in_fb (= read_en), hsync window and vsync window are delayed READ_LATENCY cycles. An output register stage follows the delay:
  - de = delayed active.
  - hsync = ~delayed hsync window; vsync = ~delayed vsync window.
  - rgb = delayed in_fb ? {8{p[2]}, 8{p[1]}, 8{p[0]}} : 24'h0, where p = read_palette. Index 7 gives white (FFFFFF).
  - Active rows ≥ FB_HEIGHT show black with de = 1.
- No back-pressure. The RAM port must accept one read per cycle.

## Timing
- Reset (asynchronous, immediate):
  - h = v = 0; scroll_l = 0; all pipeline stages cleared.
  - Outputs: rgb = 0, de = 0, hsync = 1, vsync = 1, frame_start = 0, read_en = 0, read_x = read_y = 0.
- First cycle after reset release: counters at (0,0) and read_en = 1. The first frame uses scroll_l = 0.
- Latency from counter position to the rgb/de/hsync/vsync outputs is READ_LATENCY+1 cycles. All four outputs move together.
- frame_start leads the first output pixel (0,0) by READ_LATENCY+2 cycles.
- frame_start period is H_TOTAL·V_TOTAL = 554400 cycles.
- Reset asserted mid-frame: outputs take reset values without a clock edge. Scan restarts from (0,0), and no partial-pipeline data appears.

## Test plan
- Release reset, READ_LATENCY=2:
  - de rises at cycle 3 (counting from 0 at the first edge after release).
  - hsync first falls at cycle 843 and stays low exactly 128 cycles.
  - de is high for 800 of every 1056 cycles.
- Run two frames:
  - frame_start pulses exactly every 554400 cycles.
  - vsync is low for 2112 cycles per frame, with its falling edge aligned to an hsync-region line boundary.
- Wrap: scroll_x = 1000 before frame_start; RAM model returns p = x[2:0].
  - At h = 279, read_x = 1279.
  - At h = 280, read_x = 0.
  - rgb follows the model, e.g. x = 1279 → FFFFFF, x = 0 → 000000.
- Rows 300..479: read_en = 0 and rgb = 0 while de = 1. Row 299 still reads, with read_y = 299.
- Scroll latch:
  - scroll_x changed from 0 to 16 mid-frame → read_x at h = 0 stays 0 for the rest of the frame, then becomes 16 next frame.
  - scroll_x = 1280 → latched 0.
- Assert rst asynchronously mid-line at h = 500:
  - hsync = 1, de = 0, rgb = 0 before the next edge.
  - After release, timing matches scenario 1 exactly.
